// File: rtl/sdram_read.sv
// Single-word SDRAM read controller: ACTIVE, READ with auto-precharge, capture one
// 16-bit word, pulse ofin, then wait out precharge recovery before the next request.
module sdram_read #(
    parameter int unsigned T_RCD   = 2,
    parameter int unsigned CAS_LAT = 2,
    parameter int unsigned T_RP    = 2
) (
    input  logic        iclk,
    input  logic        ireset_n,
    input  logic        ireq,
    input  logic        ienb,
    input  logic [12:0] irow,
    input  logic [9:0]  icolumn,
    input  logic [1:0]  ibank,
    output logic [15:0] odata,
    output logic        ofin,
    output logic        obusy,
    output logic        DRAM_CLK,
    output logic        DRAM_CKE,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    output logic        DRAM_LDQM,
    output logic        DRAM_UDQM,
    inout  wire  [15:0] DRAM_DQ
);

    localparam int unsigned MAX_A   = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int unsigned CNT_MAX = (MAX_A > CAS_LAT) ? MAX_A : CAS_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] CMD_DESELECT = 4'b1111;
    localparam logic [3:0] CMD_NOP      = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE   = 4'b0011;
    localparam logic [3:0] CMD_READ     = 4'b0101;

    // ACTIVE and READ are issued on the edges that leave IDLE and WAIT_RCD.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RCD,
        S_WAIT_CL,
        S_CAPTURE,
        S_WAIT_RP
    } state_t;

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [3:0]         r_cmd, w_cmd;
    logic [12:0]        r_addr, w_addr;
    logic [1:0]         r_ba, w_ba;
    logic [9:0]         r_col, w_col;
    logic               r_dqm, w_dqm;
    logic [15:0]        r_odata, w_odata;
    logic               r_ofin, w_ofin;
    logic               r_obusy, w_obusy;
    logic               r_cke;

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cmd   <= CMD_DESELECT;
            r_addr  <= '0;
            r_ba    <= '0;
            r_col   <= '0;
            r_dqm   <= 1'b1;
            r_odata <= '0;
            r_ofin  <= 1'b0;
            r_obusy <= 1'b0;
            r_cke   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_cmd   <= w_cmd;
            r_addr  <= w_addr;
            r_ba    <= w_ba;
            r_col   <= w_col;
            r_dqm   <= w_dqm;
            r_odata <= w_odata;
            r_ofin  <= w_ofin;
            r_obusy <= w_obusy;
            r_cke   <= 1'b1;
        end
    end

    // Requests are ignored on the first edge after reset, while CKE is still low.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_cmd   = CMD_NOP;
        w_addr  = r_addr;
        w_ba    = r_ba;
        w_col   = r_col;
        w_dqm   = r_dqm;
        w_odata = r_odata;
        w_ofin  = 1'b0;
        w_obusy = r_obusy;
        case (r_state)
            S_IDLE: begin
                if (r_cke && ireq && ienb) begin
                    w_state = S_WAIT_RCD;
                    w_cnt   = CNT_W'(T_RCD - 1);
                    w_cmd   = CMD_ACTIVE;
                    w_addr  = irow;
                    w_ba    = ibank;
                    w_col   = icolumn;
                    w_obusy = 1'b1;
                end
            end
            S_WAIT_RCD: begin
                if (r_cnt == '0) begin
                    w_state = S_WAIT_CL;
                    w_cnt   = CNT_W'(CAS_LAT);
                    w_cmd   = CMD_READ;
                    w_addr  = {2'b00, 1'b1, r_col};
                    w_dqm   = 1'b0;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_WAIT_CL: begin
                if (r_cnt == '0) begin
                    w_state = S_CAPTURE;
                    w_odata = DRAM_DQ;
                    w_ofin  = 1'b1;
                    w_dqm   = 1'b1;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                w_state = S_WAIT_RP;
                w_cnt   = CNT_W'(T_RP - 1);
            end
            S_WAIT_RP: begin
                if (r_cnt == '0) begin
                    w_state = S_IDLE;
                    w_obusy = 1'b0;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign DRAM_DQ    = 16'bz;
    assign DRAM_CLK   = ~iclk;
    assign DRAM_CKE   = r_cke;
    assign DRAM_ADDR  = r_addr;
    assign DRAM_BA    = r_ba;
    assign DRAM_CS_N  = r_cmd[3];
    assign DRAM_RAS_N = r_cmd[2];
    assign DRAM_CAS_N = r_cmd[1];
    assign DRAM_WE_N  = r_cmd[0];
    assign DRAM_LDQM  = r_dqm;
    assign DRAM_UDQM  = r_dqm;
    assign odata      = r_odata;
    assign ofin       = r_ofin;
    assign obusy      = r_obusy;

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read: default-timing instance plus a CAS_LAT=3 instance,
// each with a small SDRAM data model driving DQ around the expected capture edge.
module tb_sdram_read;

    localparam logic [3:0] C_DES = 4'b1111;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ireq = 1'b0, ienb = 1'b0;
    logic [12:0] irow = '0;
    logic [9:0]  icol = '0;
    logic [1:0]  ibank = '0;

    logic [15:0] odata, odata3;
    logic        ofin, ofin3, obusy, obusy3;
    logic        dclk, dclk3, cke, cke3;
    logic [12:0] addr, addr3;
    logic [1:0]  ba, ba3;
    logic        cs, ras, cas, we, cs3, ras3, cas3, we3;
    logic        ldqm, udqm, ldqm3, udqm3;
    wire  [15:0] dq, dq3;
    logic [3:0]  cmd, cmd3;

    assign cmd  = {cs, ras, cas, we};
    assign cmd3 = {cs3, ras3, cas3, we3};

    sdram_read dut (
        .iclk(clk), .ireset_n(rst_n), .ireq(ireq), .ienb(ienb),
        .irow(irow), .icolumn(icol), .ibank(ibank),
        .odata(odata), .ofin(ofin), .obusy(obusy),
        .DRAM_CLK(dclk), .DRAM_CKE(cke), .DRAM_ADDR(addr), .DRAM_BA(ba),
        .DRAM_CS_N(cs), .DRAM_RAS_N(ras), .DRAM_CAS_N(cas), .DRAM_WE_N(we),
        .DRAM_LDQM(ldqm), .DRAM_UDQM(udqm), .DRAM_DQ(dq)
    );

    sdram_read #(.T_RCD(2), .CAS_LAT(3), .T_RP(2)) dut3 (
        .iclk(clk), .ireset_n(rst_n), .ireq(ireq), .ienb(ienb),
        .irow(irow), .icolumn(icol), .ibank(ibank),
        .odata(odata3), .ofin(ofin3), .obusy(obusy3),
        .DRAM_CLK(dclk3), .DRAM_CKE(cke3), .DRAM_ADDR(addr3), .DRAM_BA(ba3),
        .DRAM_CS_N(cs3), .DRAM_RAS_N(ras3), .DRAM_CAS_N(cas3), .DRAM_WE_N(we3),
        .DRAM_LDQM(ldqm3), .DRAM_UDQM(udqm3), .DRAM_DQ(dq3)
    );

    always #5 clk = ~clk;

    // SDRAM model: READ seen mid-cycle, data driven for one cycle CL cycles later.
    logic [15:0] mdata = '0;
    logic        drv = 1'b0, drv3 = 1'b0;
    int          k = 0, k3 = 0;
    assign dq  = drv  ? mdata : 16'bz;
    assign dq3 = drv3 ? mdata : 16'bz;

    always @(negedge clk) begin
        if (drv) drv = 1'b0;
        if (k > 0) begin
            k = k - 1;
            if (k == 0) drv = 1'b1;
        end
        if (cmd == C_RD) k = 2;
    end

    always @(negedge clk) begin
        if (drv3) drv3 = 1'b0;
        if (k3 > 0) begin
            k3 = k3 - 1;
            if (k3 == 0) drv3 = 1'b1;
        end
        if (cmd3 == C_RD) k3 = 3;
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && (obusy || obusy3); i++) step();
        chk("idle_timeout", {30'd0, obusy, obusy3}, 32'd0);
    endtask

    typedef struct {
        logic [12:0] row;
        logic [9:0]  col;
        logic [1:0]  bank;
        logic [15:0] data;
        logic [12:0] exp_rd_addr;
    } vec_t;

    vec_t vecs[4];

    task automatic run_read(input vec_t v);
        irow = v.row; icol = v.col; ibank = v.bank; mdata = v.data;
        ireq = 1'b1; ienb = 1'b1;
        step();                                  // E0
        chk("act_cmd", 32'(cmd), 32'(C_ACT));
        chk("act_addr", 32'(addr), 32'(v.row));
        chk("act_ba", 32'(ba), 32'(v.bank));
        chk("busy_rise", 32'(obusy), 32'd1);
        ireq = 1'b0;
        step();                                  // E0+1
        chk("rcd_nop", 32'(cmd), 32'(C_NOP));
        step();                                  // E0+2
        chk("rd_cmd", 32'(cmd), 32'(C_RD));
        chk("rd_addr", 32'(addr), 32'(v.exp_rd_addr));
        chk("rd_ba", 32'(ba), 32'(v.bank));
        chk("rd_dqm", 32'({ldqm, udqm}), 32'd0);
        step(); step();                          // E0+4
        chk("fin_early", 32'(ofin), 32'd0);
        step();                                  // E0+5
        chk("fin_pulse", 32'(ofin), 32'd1);
        chk("fin_data", 32'(odata), 32'(v.data));
        chk("cap_dqm", 32'({ldqm, udqm}), 32'd3);
        step();                                  // E0+6
        chk("fin_one", 32'(ofin), 32'd0);
        step();                                  // E0+7
        chk("busy_hold", 32'(obusy), 32'd1);
        step();                                  // E0+8
        chk("busy_fall", 32'(obusy), 32'd0);
        wait_idle();
    endtask

    initial begin
        int nbad, nof, nact, badba, badrd;
        int act_cyc[4];
        logic [15:0] fdat[4];

        vecs[0] = '{13'h0155, 10'h02A, 2'd2, 16'h001D, 13'h042A};
        vecs[1] = '{13'h1FFF, 10'h3FF, 2'd3, 16'hFFFF, 13'h07FF};
        vecs[2] = '{13'h0000, 10'h000, 2'd0, 16'h0000, 13'h0400};
        vecs[3] = '{13'h0A5A, 10'h155, 2'd1, 16'h1234, 13'h0555};

        // Reset held with a pending request
        rst_n = 1'b0; ireq = 1'b1; ienb = 1'b1; irow = 13'h1234; ibank = 2'd3;
        step(); step(); step();
        chk("rst_cmd", 32'(cmd), 32'(C_DES));
        chk("rst_cke", 32'(cke), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_ba", 32'(ba), 32'd0);
        chk("rst_dqm", 32'({ldqm, udqm}), 32'd3);
        chk("rst_out", 32'({odata, ofin, obusy}), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_cke", 32'(cke), 32'd1);
        chk("rel_nop", 32'(cmd), 32'(C_NOP));

        // ienb gating
        ienb = 1'b0;
        nbad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cmd != C_NOP || obusy) nbad++;
        end
        chk("gate_nops", 32'(nbad), 32'd0);
        irow = 13'h0077; icol = 10'h011; ibank = 2'd1; mdata = 16'h4242;
        ienb = 1'b1;
        step();
        chk("gate_act", 32'(cmd), 32'(C_ACT));
        chk("gate_addr", 32'(addr), 32'h0077);
        ireq = 1'b0; ienb = 1'b0;
        wait_idle();
        chk("gate_data", 32'(odata), 32'h4242);

        // Single reads from the vector table
        for (int i = 0; i < 4; i++) run_read(vecs[i]);

        // Inputs changed mid-transaction
        irow = 13'h0123; icol = 10'h0F0; ibank = 2'd1; mdata = 16'hBEEF;
        ireq = 1'b1; ienb = 1'b1;
        step();
        chk("mid_act", 32'(cmd), 32'(C_ACT));
        nof = 0; nact = 0; badba = 0; badrd = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin ienb = 1'b0; irow = 13'h1ABC; icol = 10'h3C3; ibank = 2'd2; end
            if (c == 4) ienb = 1'b1;
            if (c == 5) ienb = 1'b0;
            step();
            if (ofin) begin nof++; fdat[0] = odata; end
            if (cmd == C_ACT) nact++;
            if (obusy && ba != 2'd1) badba++;
            if (cmd == C_RD && addr != 13'h04F0) badrd++;
        end
        ireq = 1'b0;
        chk("mid_fin_cnt", 32'(nof), 32'd1);
        chk("mid_data", 32'(fdat[0]), 32'hBEEF);
        chk("mid_no_act", 32'(nact), 32'd0);
        chk("mid_ba", 32'(badba), 32'd0);
        chk("mid_rd_addr", 32'(badrd), 32'd0);
        wait_idle();

        // Back-to-back reads
        irow = 13'h0200; icol = 10'h001; ibank = 2'd3; mdata = 16'hA5A5;
        ireq = 1'b1; ienb = 1'b1;
        nact = 0; nof = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (cmd == C_ACT && nact < 4) begin act_cyc[nact] = c; nact++; end
            if (nact == 2) ireq = 1'b0;
            if (ofin && nof < 4) begin
                fdat[nof] = odata; nof++;
                if (nof == 1) mdata = 16'h5A5A;
            end
        end
        ireq = 1'b0;
        chk("b2b_act_cnt", 32'(nact), 32'd2);
        chk("b2b_period", 32'(act_cyc[1] - act_cyc[0]), 32'd9);
        chk("b2b_fin_cnt", 32'(nof), 32'd2);
        chk("b2b_data0", 32'(fdat[0]), 32'hA5A5);
        chk("b2b_data1", 32'(fdat[1]), 32'h5A5A);
        wait_idle();

        // Reset in WAIT_CL
        irow = 13'h0101; icol = 10'h055; ibank = 2'd2; mdata = 16'h7777;
        ireq = 1'b1; ienb = 1'b1;
        step();
        ireq = 1'b0;
        step(); step(); step();                  // E0+3
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_cmd", 32'(cmd), 32'(C_DES));
        chk("mrst_cke", 32'(cke), 32'd0);
        chk("mrst_addr_ba", 32'({addr, ba}), 32'd0);
        chk("mrst_dqm", 32'({ldqm, udqm}), 32'd3);
        chk("mrst_out", 32'({odata, ofin, obusy}), 32'd0);
        nof = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ofin || ofin3) nof++;
        end
        chk("mrst_no_fin", 32'(nof), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mrst_rel_nop", 32'(cmd), 32'(C_NOP));

        // CAS latency 3 against CAS latency 2
        irow = 13'h0033; icol = 10'h2CC; ibank = 2'd2; mdata = 16'h0C3C;
        ireq = 1'b1; ienb = 1'b1;
        step();                                  // E0
        chk("cl3_act", 32'(cmd3), 32'(C_ACT));
        ireq = 1'b0;
        step(); step();                          // E0+2
        chk("cl3_rd", 32'(cmd3), 32'(C_RD));
        chk("cl3_rd_addr", 32'(addr3), 32'h06CC);
        step(); step(); step();                  // E0+5
        chk("cl3_not_yet", 32'(ofin3), 32'd0);
        chk("cl2_fin", 32'(ofin), 32'd1);
        step();                                  // E0+6
        chk("cl3_fin", 32'(ofin3), 32'd1);
        chk("cl3_data", 32'(odata3), 32'h0C3C);
        step(); step();                          // E0+8
        chk("cl3_busy", 32'(obusy3), 32'd1);
        step();                                  // E0+9
        chk("cl3_busy_fall", 32'(obusy3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_read.md
# sdram_read

Single-word SDRAM read controller: the read-side counterpart of the existing SDRAM write block, sharing its request/enable/finish handshake and its DRAM pin set. On a request, it activates the addressed row, issues a READ with auto-precharge, captures the returned 16-bit word, pulses `ofin`, and waits out precharge recovery before accepting the next request. It sits between the user-side memory arbiter and the SDRAM pins. It runs only after the init block has programmed the mode register for burst length 1 and CAS latency `CAS_LAT`.

## Interface
- `T_RCD`, default 2: ACTIVE-to-READ delay in iclk cycles (≥1).
- `CAS_LAT`, default 2: CAS latency in cycles (2 or 3); must match the mode register.
- `T_RP`, default 2: recovery cycles after capture before returning to IDLE (≥1).
- `iclk`, in, 1: system clock. Sole clock.
- `ireset_n`, in, 1: asynchronous active-low reset.
- `ireq`, in, 1: read request, level-sampled in IDLE only.
- `ienb`, in, 1: enable; a read starts only when `ireq` and `ienb` are both high.
- `irow`, in, 13: row address, latched at start.
- `icolumn`, in, 10: column address, latched at start.
- `ibank`, in, 2: bank address, latched at start.
- `odata`, out, 16: read word, held until the next capture.
- `ofin`, out, 1: one-cycle pulse marking `odata` valid.
- `obusy`, out, 1: high from the start edge until the return to IDLE.
- `DRAM_CLK`, out, 1: `~iclk`, so the SDRAM samples mid-cycle.
- `DRAM_CKE`, out, 1: clock enable.
- `DRAM_ADDR`, out, 13: SDRAM address.
- `DRAM_BA`, out, 2: SDRAM bank.
- `DRAM_CS_N`, `DRAM_RAS_N`, `DRAM_CAS_N`, `DRAM_WE_N`, out, 1 each: command pins.
- `DRAM_LDQM`, `DRAM_UDQM`, out, 1 each: byte masks.
- `DRAM_DQ`, inout, 16: data bus. This block never drives it (permanently high-Z).

## Operation
- Command encodings as {CS_N,RAS_N,CAS_N,WE_N}: DESELECT 1111, NOP 0111, ACTIVE 0011, READ 0101.
- All pin outputs, `odata`, `ofin` and `obusy` are registered on the rising edge of `iclk`.
- Reset values (immediate on `ireset_n` low):
  - State is IDLE.
  - Command is DESELECT, `DRAM_CKE`=0.
  - `DRAM_ADDR`=0, `DRAM_BA`=0.
  - `DRAM_LDQM`/`DRAM_UDQM`=1.
  - `odata`=0, `ofin`=0, `obusy`=0.
- After reset release, the first edge sets `DRAM_CKE`=1 and the command to NOP. These persist in IDLE.
- States: IDLE → ACTIVATE → WAIT_RCD → READ → WAIT_CL → CAPTURE → WAIT_RP → IDLE.
- IDLE: on an edge with `ireq & ienb`:
  - latch `irow`/`icolumn`/`ibank`;
  - drive ACTIVE with `DRAM_ADDR`=row and `DRAM_BA`=bank;
  - set `obusy`=1 and enter WAIT_RCD.
- WAIT_RCD: NOP for `T_RCD`-1 cycles, then drive READ.
  - `DRAM_ADDR` = {2'b00, 1'b1 (A10, auto-precharge), column[9:0]}.
  - `DRAM_BA` = latched bank.
  - `DRAM_LDQM`/`DRAM_UDQM` = 0.
- WAIT_CL: NOP for `CAS_LAT` cycles. DQM stays low.
- CAPTURE: `odata` ← `DRAM_DQ`, `ofin`=1 for exactly one cycle, DQM returns to 1.
- WAIT_RP: NOP for `T_RP` cycles, then IDLE with `obusy`=0.
- `DRAM_BA` holds the latched bank from ACTIVE until IDLE.
- `ireq`, `ienb` and address inputs are ignored outside IDLE. A mid-transaction `ienb` drop or address change has no effect.
- If `ireq & ienb` is still high on the edge that enters IDLE, it is not sampled. The next read starts on the following edge.
- Reset asserted mid-transaction aborts immediately: reset values, no `ofin`. The SDRAM bank state is left to the init block's re-initialisation.

## Timing
- Let E0 be the start edge.
- ACTIVE is visible during cycle E0..E0+1.
- READ is issued at edge E0+`T_RCD`.
- Capture and `ofin` rise at edge E0+`T_RCD`+`CAS_LAT`+1. With defaults this is E0+5.
- `obusy` falls at edge E0+`T_RCD`+`CAS_LAT`+1+`T_RP`+1. With defaults this is E0+8.
- The earliest next start is one edge after that. Back-to-back period with defaults: 9 cycles.
- `odata` is stable from the `ofin` edge until the next CAPTURE or reset.

## Test plan
- **Reset:** hold `ireset_n`=0 with `ireq`=`ienb`=1.
  - All outputs stay at reset values, `DRAM_DQ` is high-Z.
  - On release, CKE=1 and NOP on the first edge. No ACTIVE on that edge.
- **Single read:** row=0x0155, col=0x2A, bank=2, model drives 16'h001D after CL.
  - ACTIVE with ADDR=0x0155, BA=2 at E0.
  - READ with ADDR=0x042A at E0+2.
  - `ofin` pulse at E0+5 with `odata`=16'h001D.
  - `obusy` low at E0+8.
- **`ienb` gating:** `ireq`=1, `ienb`=0 for 10 cycles, then `ienb`=1.
  - Only NOPs while `ienb`=0.
  - ACTIVE on the first edge with `ienb`=1.
- **Mid-transaction input changes:** toggle `ienb` and change `irow` during WAIT_CL.
  - The transaction completes unchanged with latched addresses.
  - Exactly one `ofin`.
- **Back-to-back:** hold `ireq`=`ienb`=1 for two reads returning 16'hA5A5 then 16'h5A5A.
  - Second ACTIVE exactly 9 cycles after the first.
  - Two `ofin` pulses, each with the correct `odata`.
- **Reset mid-op and CAS_LAT=3:** assert `ireset_n`=0 in WAIT_CL.
  - Outputs go to reset values asynchronously, no `ofin`.
  - Rerun with `CAS_LAT`=3: `ofin` at E0+6.
